// File: rtl/vga_fill_engine.sv
// Framebuffer write feeder: queues CPU pixel writes and runs hardware rectangle fills.
// Optional fill-done interrupt enabled by defining VGA_FILL_IRQ_EN.
module vga_fill_engine #(
  parameter int unsigned HSIZE      = 800,
  parameter int unsigned VSIZE      = 600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              clk_25M,
  input  logic              rst,
  input  logic              bus_we,
  input  logic [31:0]       bus_addr,
  input  logic [31:0]       bus_data,
  output logic              bus_stall,
  output logic [31:0]       bus_rdata,
  output logic              write_op,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              irq
);

  localparam int unsigned       AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       DEPTH_P = (AW+1)'(FIFO_DEPTH);
  localparam logic [12:0]       HSIZE_C = 13'(HSIZE);
  localparam logic [12:0]       VSIZE_C = 13'(VSIZE);
  localparam logic [ADDR_W-1:0] PITCH   = ADDR_W'(HSIZE);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  state_e            state_q;
  logic [11:0]       x0_q, y0_q, w_q, h_q;
  logic [7:0]        color_q;
  logic              start_pend_q, err_q;
  logic [12:0]       fill_x0_q, x_q, y_q, x_last_q, y_last_q;
  logic [ADDR_W-1:0] rowbase_q;

  // Direct-write FIFO
  logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wptr_q, rptr_q, fifo_level;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W+7:0] head;

  logic pix_we, reg_we, cmd_we, push_ok, pop, bypass, fifo_push;
  logic idle, busy, start_acc;

  assign fifo_level = wptr_q - rptr_q;
  assign fifo_full  = (fifo_level == DEPTH_P);
  assign fifo_empty = (fifo_level == '0);
  assign head       = fifo_mem[rptr_q[AW-1:0]];

  assign pix_we    = bus_we & ~bus_addr[19];
  assign reg_we    = bus_we & bus_addr[19];
  assign cmd_we    = reg_we & (bus_addr[3:2] == 2'd3);
  assign bus_stall = pix_we & fifo_full;
  assign push_ok   = pix_we & ~fifo_full;

  assign idle      = (state_q == StIdle);
  assign busy      = ~idle | start_pend_q;
  assign start_acc = cmd_we & bus_data[0] & ~busy;
  assign pop       = idle & ~fifo_empty;
  // An idle engine with nothing queued writes the pixel straight out, saving a cycle.
  assign bypass    = idle & fifo_empty & ~start_pend_q & push_ok;
  assign fifo_push = push_ok & ~bypass;

  assign bus_rdata = {22'b0, irq, err_q, busy, 1'b0, 6'(fifo_level)};

  // Setup-time clipping; sums are 13 bits so they cannot wrap
  logic [12:0]       x_end, y_end, x_clip, y_clip;
  logic              fill_empty;
  logic [ADDR_W-1:0] setup_row;

  assign x_end      = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end      = {1'b0, y0_q} + {1'b0, h_q};
  assign x_clip     = (x_end > HSIZE_C) ? HSIZE_C : x_end;
  assign y_clip     = (y_end > VSIZE_C) ? VSIZE_C : y_end;
  assign fill_empty = (w_q == '0) | (h_q == '0) | ({1'b0, x0_q} >= HSIZE_C) |
                      ({1'b0, y0_q} >= VSIZE_C);
  assign setup_row  = ADDR_W'(y0_q) * PITCH;

  // Cursor x_q/y_q/rowbase_q names the pixel currently on the output
  logic              row_end, fill_last;
  logic [12:0]       nx;
  logic [ADDR_W-1:0] nrow;

  assign row_end   = (x_q == x_last_q);
  assign fill_last = row_end & (y_q == y_last_q);
  assign nx        = row_end ? fill_x0_q : x_q + 13'd1;
  assign nrow      = row_end ? rowbase_q + PITCH : rowbase_q;

  always_ff @(posedge clk_25M) begin
    if (fifo_push) fifo_mem[wptr_q[AW-1:0]] <= {bus_addr[ADDR_W-1:0], bus_data[7:0]};
  end

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (fifo_push) wptr_q <= wptr_q + 1'b1;
      if (pop)       rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      color_q      <= '0;
      start_pend_q <= 1'b0;
      err_q        <= 1'b0;
      fill_x0_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      x_last_q     <= '0;
      y_last_q     <= '0;
      rowbase_q    <= '0;
      write_op     <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
`ifdef VGA_FILL_IRQ_EN
      irq          <= 1'b0;
`endif
    end else begin
      if (reg_we) begin
        case (bus_addr[3:2])
          2'd0: begin
            y0_q <= bus_data[27:16];
            x0_q <= bus_data[11:0];
          end
          2'd1: begin
            h_q <= bus_data[27:16];
            w_q <= bus_data[11:0];
          end
          2'd2: color_q <= bus_data[7:0];
          default: begin
            if (bus_data[1]) begin
              err_q <= 1'b0;
`ifdef VGA_FILL_IRQ_EN
              irq   <= 1'b0;
`endif
            end
            if (bus_data[0] && busy) err_q <= 1'b1;
          end
        endcase
      end

      unique case (state_q)
        StIdle: begin
          write_op <= 1'b0;
          if (!fifo_empty) begin
            write_op <= 1'b1;
            fb_addr  <= head[ADDR_W+7:8];
            fb_data  <= head[7:0];
            if (start_acc) start_pend_q <= 1'b1;
          end else if (start_pend_q || start_acc) begin
            start_pend_q <= 1'b0;
            state_q      <= StSetup;
          end else if (bypass) begin
            write_op <= 1'b1;
            fb_addr  <= bus_addr[ADDR_W-1:0];
            fb_data  <= bus_data[7:0];
          end
        end
        StSetup: begin
          fill_x0_q <= {1'b0, x0_q};
          x_q       <= {1'b0, x0_q};
          y_q       <= {1'b0, y0_q};
          rowbase_q <= setup_row;
          x_last_q  <= x_clip - 13'd1;
          y_last_q  <= y_clip - 13'd1;
          if (fill_empty) begin
            state_q <= StDone;
          end else begin
            write_op <= 1'b1;
            fb_addr  <= setup_row + ADDR_W'(x0_q);
            fb_data  <= color_q;
            state_q  <= StFill;
          end
        end
        StFill: begin
          if (fill_last) begin
            write_op <= 1'b0;
            state_q  <= StDone;
          end else begin
            x_q       <= nx;
            y_q       <= row_end ? y_q + 13'd1 : y_q;
            rowbase_q <= nrow;
            fb_addr   <= nrow + ADDR_W'(nx);
          end
        end
        StDone: begin
          write_op <= 1'b0;
          state_q  <= StIdle;
`ifdef VGA_FILL_IRQ_EN
          irq      <= 1'b1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef VGA_FILL_IRQ_EN
  assign irq = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus_addr[31:20], bus_addr[1:0], bus_data[31:28], bus_data[15:12]};

endmodule

// File: tb/tb_vga_fill_engine.sv
// Self-checking bench for vga_fill_engine: vector table for pixel writes and a basic fill,
// followed by directed sequences for clipping, stalls, errors, irq and mid-fill reset.
module tb_vga_fill_engine;

  logic        clk_25M = 1'b0;
  logic        rst;
  logic        bus_we;
  logic [31:0] bus_addr, bus_data;
  logic        bus_stall;
  logic [31:0] bus_rdata;
  logic        write_op;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [26:0] wq[$];

  vga_fill_engine dut (
    .clk_25M   (clk_25M),
    .rst       (rst),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_stall (bus_stall),
    .bus_rdata (bus_rdata),
    .write_op  (write_op),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .irq       (irq)
  );

  always #5 clk_25M = ~clk_25M;

  always @(negedge clk_25M) if (write_op) wq.push_back({fb_addr, fb_data});

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ewop;
    logic [18:0] eaddr;
    logic [7:0]  edata;
    logic        estall;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] d, logic ewop,
                              logic [18:0] ea, logic [7:0] ed, logic est, logic eb);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.ewop = ewop;
    v.eaddr = ea; v.edata = ed; v.estall = est; v.ebusy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25M);
    #1;
  endtask

  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_data = d;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d);
    bus_cycle(32'h0008_0000 | (32'(idx) << 2), d);
  endtask

  task automatic setup_fill(input int x0, input int y0, input int w, input int h,
                            input logic [7:0] c);
    reg_wr(0, (32'(y0) << 16) | 32'(x0));
    reg_wr(1, (32'(h) << 16) | 32'(w));
    reg_wr(2, 32'(c));
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk_25M);
      if (bus_rdata[7] == 1'b0 && bus_rdata[5:0] == 6'd0) done = 1'b1;
      tick();
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_wq(input string name, input int idx, input logic [18:0] ea,
                          input logic [7:0] ed);
    logic [26:0] got;
    got = (idx < wq.size()) ? wq[idx] : 27'h7ff_ffff;
    check($sformatf("%s[%0d]", name, idx), 32'(got), 32'({ea, ed}));
  endtask

  initial begin
    bit accepted;
    int nbusy;

    rst = 1'b1; bus_we = 1'b0; bus_addr = '0; bus_data = '0;
    repeat (2) @(posedge clk_25M);
    @(negedge clk_25M);
    check("reset write_op", 32'(write_op), 32'd0);
    check("reset fb_addr", 32'(fb_addr), 32'd0);
    check("reset fb_data", 32'(fb_data), 32'd0);
    check("reset bus_rdata", bus_rdata, 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    @(posedge clk_25M);
    #1 rst = 1'b0;

    // Pixel writes then a 3x2 fill at (10,2)
    vecs.push_back(mk(1, 32'h10, 32'hE0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h11, 32'h07, 1, 19'h10, 8'hE0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 19'h11, 8'h07, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8_0000, (32'd2 << 16) | 32'd10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8_0004, (32'd2 << 16) | 32'd3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8_0008, 32'h1C, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8_000C, 32'h1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 19'd1610, 8'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 19'd1611, 8'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 19'd1612, 8'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 19'd2410, 8'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 19'd2411, 8'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 19'd2412, 8'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      bus_we = vecs[i].we; bus_addr = vecs[i].addr; bus_data = vecs[i].data;
      @(negedge clk_25M);
      check($sformatf("vec%0d write_op", i), 32'(write_op), 32'(vecs[i].ewop));
      check($sformatf("vec%0d stall", i), 32'(bus_stall), 32'(vecs[i].estall));
      check($sformatf("vec%0d busy", i), 32'(bus_rdata[7]), 32'(vecs[i].ebusy));
      if (vecs[i].ewop) begin
        check($sformatf("vec%0d fb_addr", i), 32'(fb_addr), 32'(vecs[i].eaddr));
        check($sformatf("vec%0d fb_data", i), 32'(fb_data), 32'(vecs[i].edata));
      end
      tick();
    end
    bus_we = 1'b0;

    // Fill clipped at the bottom-right corner
    reg_wr(3, 32'h2);
    wq.delete();
    setup_fill(798, 599, 5, 5, 8'h3C);
    reg_wr(3, 32'h1);
    wait_idle("clip idle", 50);
    check("clip count", 32'(wq.size()), 32'd2);
    check_wq("clip", 0, 19'd479998, 8'h3C);
    check_wq("clip", 1, 19'd479999, 8'h3C);

    // Zero-width fill started with clear+start together
    reg_wr(1, (32'd5 << 16));
    wq.delete();
    reg_wr(3, 32'h3);
    nbusy = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk_25M);
      if (bus_rdata[7]) nbusy++;
      tick();
    end
    check("w0 busy cycles", 32'(nbusy), 32'd2);
    check("w0 no writes", 32'(wq.size()), 32'd0);
    check("w0 err", 32'(bus_rdata[8]), 32'd0);
`ifdef VGA_FILL_IRQ_EN
    check("w0 irq", 32'(irq), 32'd1);
`else
    check("w0 irq", 32'(irq), 32'd0);
`endif
    reg_wr(3, 32'h2);

    // Five pixel writes during a 100-pixel fill
    wq.delete();
    setup_fill(0, 5, 100, 1, 8'h55);
    reg_wr(3, 32'h1);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      bus_we = 1'b1; bus_addr = 32'h100 + 32'(i); bus_data = 32'hA0 + 32'(i);
      @(negedge clk_25M);
      check($sformatf("fifo push%0d stall", i), 32'(bus_stall), 32'd0);
      tick();
    end
    bus_addr = 32'h104; bus_data = 32'hA4;
    @(negedge clk_25M);
    check("fifo full stall", 32'(bus_stall), 32'd1);
    check("fifo full level", 32'(bus_rdata[5:0]), 32'd4);
    tick();
    accepted = 1'b0;
    for (int t = 0; t < 300 && !accepted; t++) begin
      @(negedge clk_25M);
      if (!bus_stall) accepted = 1'b1;
      tick();
    end
    bus_we = 1'b0;
    check("retry accepted", 32'(accepted), 32'd1);
    wait_idle("fill100 idle", 50);
    tick(); tick();
    check("fill100 count", 32'(wq.size()), 32'd105);
    for (int i = 0; i < 100; i++) check_wq("fill100", i, 19'(4000 + i), 8'h55);
    for (int i = 0; i < 5; i++) check_wq("drain", 100 + i, 19'(32'h100 + i), 8'(8'hA0 + i));

    // Start while busy, register rewrite mid-fill
    wq.delete();
    setup_fill(0, 10, 20, 1, 8'h33);
    reg_wr(3, 32'h1);
    tick(); tick();
    reg_wr(2, 32'hFF);
    reg_wr(3, 32'h1);
    @(negedge clk_25M);
    check("err set", 32'(bus_rdata[8]), 32'd1);
    tick();
    wait_idle("err fill idle", 50);
`ifdef VGA_FILL_IRQ_EN
    check("irq after done", 32'(irq), 32'd1);
    check("rdata irq bit", 32'(bus_rdata[9]), 32'd1);
`endif
    repeat (5) tick();
    check("err fill count", 32'(wq.size()), 32'd20);
    for (int i = 0; i < 20; i++) check_wq("err fill", i, 19'(8000 + i), 8'h33);
    reg_wr(3, 32'h2);
    @(negedge clk_25M);
    check("err cleared", 32'(bus_rdata[8]), 32'd0);
    check("irq cleared", 32'(irq), 32'd0);
    check("rdata irq cleared", 32'(bus_rdata[9]), 32'd0);
    tick();

    // Reset in the middle of a fill with FIFO entries queued
    setup_fill(0, 0, 50, 4, 8'h77);
    reg_wr(3, 32'h1);
    tick();
    bus_cycle(32'h200, 32'h11);
    bus_cycle(32'h201, 32'h22);
    @(negedge clk_25M);
    check("pre-reset write_op", 32'(write_op), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("reset write_op now", 32'(write_op), 32'd0);
    check("reset rdata now", bus_rdata, 32'd0);
    check("reset fb_addr now", 32'(fb_addr), 32'd0);
    @(posedge clk_25M);
    #1 rst = 1'b0;
    wq.delete();
    @(negedge clk_25M);
    check("post-reset rdata", bus_rdata, 32'd0);
    tick();
    repeat (5) tick();
    check("post-reset no drain", 32'(wq.size()), 32'd0);
    reg_wr(3, 32'h1);
    wait_idle("post-reset fill idle", 20);
    check("post-reset regs zero", 32'(wq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
